sevenseg_mux_pwm: RTL

Parametrised, time-multiplexed driver for N-digit common-anode seven-segment displays with active-low segment and anode outputs. It decodes full hex (0-F) with a per-digit decimal point, per-digit enable and optional leading-zero blanking. Brightness is set by PWM of the anode within each digit slot. Inputs are snapshotted once per frame to prevent tearing. It sits between the PWM/status logic and the board display pins.

---
 rtl/sevenseg_pkg.sv | 31 +++
 rtl/seg_hex_decode.sv | 12 +
 rtl/sevenseg_mux_pwm.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment display driver:
// hex segment patterns and parameter legality helper.
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110,
        7'b0000110,
        7'b0100001,
        7'b1000110,
        7'b0000011,
        7'b0001000,
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };

    function automatic bit params_ok(int nd, int dl, int bw);
        return (nd >= 2) && (nd <= 8) && (bw >= 1) && (bw <= dl - 1);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-low segment decoder.
// Pure table lookup into the shared pattern constant.
module seg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_HEX[i_val];

endmodule

// File: rtl/sevenseg_mux_pwm.sv
// Multiplexed N-digit seven-segment driver with PWM brightness,
// leading-zero blanking and per-frame input snapshot.
module sevenseg_mux_pwm
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_LOG2   = 16,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (!params_ok(NUM_DIGITS, DIV_LOG2, BRIGHT_W)) begin : g_bad_params
        $error("sevenseg_mux_pwm: illegal parameter combination");
    end

    logic [DIV_LOG2-1:0]     r_p;
    logic [DW-1:0]           r_d;
    logic [4*NUM_DIGITS-1:0] r_dig_s;
    logic [NUM_DIGITS-1:0]   r_dp_s;
    logic [NUM_DIGITS-1:0]   r_en_s;
    logic [BRIGHT_W-1:0]     r_br_s;
    logic                    r_lz_s;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_fs;

    logic [3:0]              w_cur_dig;
    logic                    w_cur_dp;
    logic                    w_cur_en;
    logic                    w_cur_blank;
    logic                    w_all_zero;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic [6:0]              w_seg;
    logic                    w_pwm_on;
    logic                    w_lit;
    logic                    w_frame;

    seg_hex_decode u_dec (
        .i_val (w_cur_dig),
        .o_seg (w_seg)
    );

    // Select the current slot's digit and work out blanking, scanning
    // from the most significant digit so zeros accumulate downwards.
    always_comb begin
        w_cur_dig   = 4'd0;
        w_cur_dp    = 1'b0;
        w_cur_en    = 1'b0;
        w_cur_blank = 1'b0;
        w_all_zero  = 1'b1;
        w_an_sel    = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_all_zero = w_all_zero & (r_dig_s[4*i +: 4] == 4'd0);
            if (r_d == DW'(i)) begin
                w_cur_dig   = r_dig_s[4*i +: 4];
                w_cur_dp    = r_dp_s[i];
                w_cur_en    = r_en_s[i];
                w_cur_blank = r_lz_s && (i != 0) && w_all_zero;
                w_an_sel[i] = 1'b0;
            end
        end
    end

    assign w_pwm_on = (&r_br_s)
                    || (r_p[DIV_LOG2-1 -: BRIGHT_W] < r_br_s);
    assign w_frame  = (r_p == '0) && (r_d == '0);
    assign w_lit    = (r_p != '0) && w_cur_en && !w_cur_blank && w_pwm_on;

    // Free-running prescaler and slot counter wrapping at NUM_DIGITS.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_p <= '0;
            r_d <= '0;
        end else begin
            r_p <= r_p + 1'b1;
            if (&r_p) begin
                r_d <= (r_d == DW'(NUM_DIGITS - 1)) ? '0 : r_d + 1'b1;
            end
        end
    end

    // Capture all display inputs once, at the start of slot 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dig_s <= '0;
            r_dp_s  <= '0;
            r_en_s  <= '0;
            r_br_s  <= '0;
            r_lz_s  <= 1'b0;
        end else if (w_frame) begin
            r_dig_s <= digits;
            r_dp_s  <= dp_in;
            r_en_s  <= digit_en;
            r_br_s  <= brightness;
            r_lz_s  <= lz_blank;
        end
    end

    // Registered pin outputs; everything dark when not lit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
            r_an  <= '1;
            r_fs  <= 1'b0;
        end else begin
            r_seg <= w_lit ? w_seg : SEG_BLANK;
            r_dp  <= w_lit ? ~w_cur_dp : 1'b1;
            r_an  <= w_lit ? w_an_sel : '1;
            r_fs  <= w_frame;
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign frame_start = r_fs;

endmodule
